// File: rtl/instr_decode_pkg.sv
// Shared instruction-set constants and the decoder state type for the instruction decoder.
package instr_decode_pkg;

  localparam logic [4:0] OP_VALL = 5'b00000;
  localparam logic [4:0] OP_VALH = 5'b00001;
  localparam logic [4:0] OP_MOVC = 5'b00010;
  localparam logic [4:0] OP_MATH = 5'b10000;
  localparam logic [4:0] OP_INCR = 5'b10010;
  localparam logic [4:0] OP_FUNC = 5'b11111;

  localparam logic [3:0] REG_R0  = 4'b0000;
  localparam logic [3:0] MATH_ADD = 4'b0000;
  localparam logic [3:0] MATH_SUB = 4'b0001;

  localparam logic [3:0] FN_LJ0  = 4'b0000;
  localparam logic [3:0] FN_LJ3  = 4'b0011;
  localparam logic [3:0] FN_SRTL = 4'b1100;
  localparam logic [3:0] FN_STRH = 4'b1101;
  localparam logic [3:0] FN_DNE  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_REPLAY,
    ST_HALT
  } dec_state_e;

endpackage

// File: rtl/instr_decode_out_reg.sv
// Single-entry valid/ready holding register for the decoded output record.
module instr_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] dout,
  output logic         slot_free
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign slot_free = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign dout      = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/instr_decode.sv
// Instruction decoder: fuses vall+valh immediate pairs and emits one registered record per word.
module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned FUSE    = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [INSTR_W-1:0]            in_instr,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OPC_W-1:0]              out_op,
  output logic [INSTR_W-OPC_W-1:0]      out_fld,
  output logic [2*(INSTR_W-OPC_W)-1:0]  out_imm,
  output logic                          out_fused,
  output logic                          out_illegal,
  output logic                          halted,
  output logic [CNT_W-1:0]              icount
);

  localparam int unsigned FLD_W = INSTR_W - OPC_W;
  localparam int unsigned REC_W = OPC_W + 3 * FLD_W + 2;

  function automatic logic is_dne(logic [OPC_W-1:0] op, logic [FLD_W-1:0] f);
    return (op == OPC_W'(OP_FUNC)) && (f == FLD_W'(FN_DNE));
  endfunction

  // Record layout: {op, fld, imm_hi, imm_lo, fused, illegal}; imm_lo is always fld.
  function automatic logic [REC_W-1:0] pack_rec(logic [OPC_W-1:0] op, logic [FLD_W-1:0] f,
                                                logic [FLD_W-1:0] hi, logic fused);
    logic legal_fn;
    legal_fn = (f <= FLD_W'(FN_LJ3)) || (f == FLD_W'(FN_SRTL)) ||
               (f == FLD_W'(FN_STRH)) || (f == FLD_W'(FN_DNE));
    return {op, f, hi, f, fused, (op == OPC_W'(OP_FUNC)) && !legal_fn};
  endfunction

  dec_state_e         state_q, state_d;
  logic [FLD_W-1:0]   held_q, held_d;
  logic [INSTR_W-1:0] stored_q, stored_d;
  logic [CNT_W-1:0]   icount_q, icount_d;
  logic               halted_q, halted_d;

  logic               load, acc, slot_free;
  logic [REC_W-1:0]   rec, rec_q;

  logic [OPC_W-1:0] in_op, st_op;
  logic [FLD_W-1:0] in_fld, st_fld;

  assign in_op  = in_instr[INSTR_W-1 -: OPC_W];
  assign in_fld = in_instr[FLD_W-1:0];
  assign st_op  = stored_q[INSTR_W-1 -: OPC_W];
  assign st_fld = stored_q[FLD_W-1:0];

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    stored_d = stored_q;
    load     = 1'b0;
    rec      = '0;
    in_ready = ((state_q == ST_IDLE) || (state_q == ST_PEND)) && slot_free && !flush;
    acc      = in_valid && in_ready;
    icount_d = icount_q + CNT_W'(acc);

    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if ((FUSE != 0) && (in_op == OPC_W'(OP_VALL))) begin
            held_d  = in_fld;
            state_d = ST_PEND;
          end else begin
            load = 1'b1;
            rec  = pack_rec(in_op, in_fld, '0, 1'b0);
            if (is_dne(in_op, in_fld)) state_d = ST_HALT;
          end
        end
      end
      ST_PEND: begin
        if (acc) begin
          load = 1'b1;
          if (in_op == OPC_W'(OP_VALH)) begin
            rec     = pack_rec(OPC_W'(OP_VALL), held_q, in_fld, 1'b1);
            state_d = ST_IDLE;
          end else begin
            // The held vall goes out unfused; the new word is kept for the next free slot.
            rec = pack_rec(OPC_W'(OP_VALL), held_q, '0, 1'b0);
            if (in_op == OPC_W'(OP_VALL)) begin
              held_d = in_fld;
            end else begin
              stored_d = in_instr;
              state_d  = ST_REPLAY;
            end
          end
        end
      end
      ST_REPLAY: begin
        if (slot_free) begin
          load    = 1'b1;
          rec     = pack_rec(st_op, st_fld, '0, 1'b0);
          state_d = is_dne(st_op, st_fld) ? ST_HALT : ST_IDLE;
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      load    = 1'b0;
      state_d = (state_q == ST_HALT) ? ST_HALT : ST_IDLE;
    end
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      held_q   <= '0;
      stored_q <= '0;
      icount_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      stored_q <= stored_d;
      icount_q <= icount_d;
      halted_q <= halted_d;
    end
  end

  instr_out_reg #(.W(REC_W)) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .load      (load),
    .din       (rec),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .dout      (rec_q),
    .slot_free (slot_free)
  );

  logic [FLD_W-1:0] imm_lo_unused;
  assign {out_op, out_fld, out_imm, out_fused, out_illegal} = {rec_q[REC_W-1 -: OPC_W + 2*FLD_W],
                                                               rec_q[FLD_W+1:0]};
  assign imm_lo_unused = rec_q[FLD_W+1:2];
  assign halted = halted_q;
  assign icount = icount_q;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode with a record-stream model checked every cycle.
module tb_instr_decode;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, out_ready;
  logic [8:0] in_instr;
  logic       in_ready, out_valid, out_fused, out_illegal, halted;
  logic [4:0] out_op;
  logic [3:0] out_fld;
  logic [7:0] out_imm;
  logic [15:0] icount;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_decode #(.INSTR_W(9), .OPC_W(5), .FUSE(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_fld(out_fld), .out_imm(out_imm), .out_fused(out_fused), .out_illegal(out_illegal),
    .halted(halted), .icount(icount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the ordered list of records the decoder owes downstream.
  typedef struct {
    logic [4:0] op;
    logic [3:0] fld;
    logic [7:0] imm;
    logic       fused;
    logic       illegal;
  } rec_t;

  rec_t        expq[$];
  logic        have_pend = 1'b0;
  logic [3:0]  pend_fld;
  logic [15:0] mcount = '0;

  function automatic rec_t mk(input logic [4:0] op, input logic [3:0] fld);
    rec_t r;
    r.op = op; r.fld = fld; r.imm = {4'h0, fld}; r.fused = 1'b0;
    r.illegal = (op == 5'b11111) && (fld inside {[4'd4:4'd11], 4'd14});
    return r;
  endfunction

  task automatic model_accept(input logic [8:0] w);
    rec_t r;
    mcount++;
    if (have_pend) begin
      if (w[8:4] == 5'b00001) begin
        r = mk(5'b00000, pend_fld);
        r.imm = {w[3:0], pend_fld};
        r.fused = 1'b1;
        expq.push_back(r);
        have_pend = 1'b0;
        return;
      end
      expq.push_back(mk(5'b00000, pend_fld));
      have_pend = 1'b0;
    end
    if (w[8:4] == 5'b00000) begin
      have_pend = 1'b1;
      pend_fld  = w[3:0];
    end else begin
      expq.push_back(mk(w[8:4], w[3:0]));
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_icount", icount, 0);
      chk("rst_halted", halted, 0);
      chk("rst_out_op", out_op, 0);
      chk("rst_out_imm", out_imm, 0);
      expq.delete();
      have_pend = 1'b0;
      mcount = '0;
    end else begin
      chk("icount", icount, mcount);
      if (halted) chk("halt_in_ready", in_ready, 0);
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_record", out_valid, 0);
        end else begin
          chk("rec_op", out_op, expq[0].op);
          chk("rec_fld", out_fld, expq[0].fld);
          chk("rec_imm", out_imm, expq[0].imm);
          chk("rec_fused", out_fused, expq[0].fused);
          chk("rec_illegal", out_illegal, expq[0].illegal);
          if (out_ready) void'(expq.pop_front());
        end
      end
      if (flush) begin
        expq.delete();
        have_pend = 1'b0;
      end else if (in_valid && in_ready) begin
        model_accept(in_instr);
      end
    end
  end

  task automatic send(input logic [8:0] w);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("send_accepted", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // Fused immediate pair
    send(9'b00000_0101);
    chk("pend_no_output", out_valid, 0);
    send(9'b00001_1010);
    chk("fused_valid", out_valid, 1);
    chk("fused_op", out_op, 5'b00000);
    chk("fused_imm", out_imm, 8'hA5);
    chk("fused_flag", out_fused, 1);
    chk("fused_icount", icount, 2);
    step(); step();

    // vall followed by non-valh goes through REPLAY
    send(9'b00000_0011);
    send(9'b10010_0100);
    chk("held_vall_imm", out_imm, 8'h03);
    chk("held_vall_fused", out_fused, 0);
    chk("replay_in_ready", in_ready, 0);
    step();
    chk("replay_op", out_op, 5'b10010);
    chk("replay_fld", out_fld, 4'b0100);
    chk("after_replay_in_ready", in_ready, 1);
    step();

    // Backpressure holds the record
    out_ready = 1'b0;
    send(9'b00010_0110);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_fld", out_fld, 4'b0110);
      chk("stall_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("consumed_once", out_valid, 0);

    // Flush while a vall is held
    send(9'b00000_0101);
    in_valid = 1'b1; in_instr = 9'b00001_0001; flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_icount", icount, 6);
    send(9'b10010_0001);
    chk("post_flush_op", out_op, 5'b10010);
    chk("post_flush_fld", out_fld, 4'b0001);
    step();

    // vall, vall, valh
    send(9'b00000_0001);
    send(9'b00000_0010);
    chk("vv_first_imm", out_imm, 8'h01);
    send(9'b00001_0011);
    chk("vv_fused_imm", out_imm, 8'h32);
    chk("vv_icount", icount, 10);
    step();

    // Function legality
    send(9'b11111_0111);
    chk("illegal_0111", out_illegal, 1);
    send(9'b11111_0010);
    chk("legal_lj2", out_illegal, 0);
    send(9'b11111_1110);
    chk("illegal_1110", out_illegal, 1);
    chk("not_halted", halted, 0);
    step();

    // Asynchronous reset while parked in REPLAY
    out_ready = 1'b0;
    send(9'b00000_0001);
    send(9'b10010_0011);
    chk("pre_reset_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_fld", out_fld, 0);
    chk("areset_fused", out_fused, 0);
    chk("areset_icount", icount, 0);
    step();
    reset = 1'b0; out_ready = 1'b1;
    chk("post_reset_in_ready", in_ready, 1);
    send(9'b10010_0111);
    chk("replay_dropped_op", out_op, 5'b10010);
    chk("replay_dropped_fld", out_fld, 4'b0111);
    step();

    // dne halts the decoder
    send(9'b11111_1111);
    chk("dne_valid", out_valid, 1);
    chk("dne_halted", halted, 1);
    in_valid = 1'b1; in_instr = 9'b10010_0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_blocks", in_ready, 0);
      chk("halt_sticky", halted, 1);
    end
    in_valid = 1'b0;
    chk("halt_icount", icount, 2);
    reset = 1'b1;
    #1 chk("halt_cleared", halted, 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have parameter INSTR_W, default 9, instruction word width.
REQ-002 SHALL have parameter OPC_W, default 5, opcode field width (instr[INSTR_W-1 -: OPC_W]); FLD_W = INSTR_W-OPC_W is derived (default 4).
REQ-003 SHALL have parameter FUSE, default 1, enabling vall+valh immediate fusion (0 disables it).
REQ-004 SHALL have parameter CNT_W, default 16, accepted-word counter width.
REQ-005 Clocking/reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  async active-high reset.
REQ-008 flush  in  1  sync discard of all held/pending state.
REQ-009 in_valid  in  1  upstream word valid.
REQ-010 in_instr  in  INSTR_W  instruction word.
REQ-011 in_ready  out  1  word accepted when in_valid&&in_ready.
REQ-012 out_valid  out  1  decoded record valid.
REQ-013 out_ready  in  1  downstream accepts record.
REQ-014 out_op  out  OPC_W  opcode.
REQ-015 out_fld  out  FLD_W  register/math/function field.
REQ-016 out_imm  out  2*FLD_W  immediate: {0,fld} unfused, {hi,lo} fused.
REQ-017 out_fused  out  1  record is a fused vall+valh.
REQ-018 out_illegal  out  1  func with field not in {lj0..lj3,srtl,strh,dne}.
REQ-019 halted  out  1  func dne has been emitted.
REQ-020 icount  out  CNT_W  count of accepted input words.

Function
REQ-021 Output is a registered record; accepted word appears with out_valid no earlier than next cycle; record holds stable while out_valid&&!out_ready.
REQ-022 States: IDLE, PEND (vall held), REPLAY (one word queued), HALT.
REQ-023 IDLE: in_ready = !out_valid||out_ready; accepted vall with FUSE=1 -> PEND, no output; any other word -> output record, stay IDLE (func dne -> HALT).
REQ-024 PEND: in_ready as IDLE; accepted valh -> emit fused record (op=vall, imm={valh.fld,vall.fld}, fused=1) -> IDLE; accepted vall -> emit held vall unfused, new vall held, stay PEND; any other word -> emit held vall, store word, -> REPLAY.
REQ-025 REPLAY: in_ready=0; emit stored word when output slot free -> IDLE (or HALT if dne).
REQ-026 HALT: in_ready=0, halted=1; leaves only on reset; last record still drains normally.
REQ-027 FUSE=0: vall never enters PEND; PEND/REPLAY unreachable.
REQ-028 icount increments by 1 per accepted word (both halves of a fused pair count), wraps at 2^CNT_W.
REQ-029 flush: out_valid->0, pending/replay dropped, state->IDLE (HALT unaffected), icount kept; flush beats a same-cycle in_valid (word not accepted, in_ready=0 that cycle).
REQ-030 out_illegal set only for op=func with fld in {0100..1011,1110}; record still emitted.

Reset
REQ-031 On reset: state=IDLE, out_valid=0, out_op/out_fld/out_imm=0, out_fused=0, out_illegal=0, halted=0, icount=0; reset mid-PEND/REPLAY discards held word.

Structure
REQ-032 Opcode, register, math and function constants plus the decoder state enum SHALL live in the shared instruction package; widths derived from parameters.
REQ-033 One sub-module, instr_out_reg (valid/ready output holding register), is natural; the FSM lives in instr_decode.

Verification
REQ-034 FUSE=1: 9'b00000_0101 then 9'b00001_1010, out_ready=1 -> one record op=00000, imm=8'hA5, fused=1; icount=2.
REQ-035 vall 0011 then incr 9'b10010_0100 -> records vall imm=8'h03 fused=0, then incr fld=0100; in_ready low one cycle (REPLAY).
REQ-036 out_ready=0 for 5 cycles with record movc src 0110 -> out_valid and fields stable, in_ready=0; released -> consumed once.
REQ-037 9'b11111_1111 -> record emitted, halted=1, in_ready=0 thereafter until reset; 9'b11111_0111 -> out_illegal=1.
REQ-038 vall held in PEND, flush asserted with in_valid=1 -> no record, word not accepted, state IDLE.
REQ-039 Reset asserted asynchronously mid-REPLAY -> all outputs at reset values before next clk edge.
